// File: rtl/pong_score_ctrl.sv
// pong_score_ctrl: match scoring, serve pause and winner blink for the two pong score digits
module pong_score_ctrl #(
  parameter int WIN_SCORE    = 9,
  parameter int PAUSE_FRAMES = 60,
  parameter int BLINK_FRAMES = 30
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       start,
  input  logic       goal_p1,
  input  logic       goal_p2,
  output logic [3:0] point1,
  output logic [3:0] point2,
  output logic       digit_en1,
  output logic       digit_en2,
  output logic       ball_run,
  output logic       game_over,
  output logic       winner
);
  localparam int CMAX = PAUSE_FRAMES > BLINK_FRAMES ? PAUSE_FRAMES : BLINK_FRAMES;
  localparam int CW   = $clog2(CMAX + 1);
  typedef enum logic [1:0] {IDLE, PLAY, SCORED, OVER} state_t;
  state_t state, state_n;
  logic g1_q, g2_q, st_q, blink, blink_n, winner_n;
  logic g1_ev, g2_ev, st_ev, pause_end, blink_end;
  logic [3:0] p1_n, p2_n;
  logic [CW-1:0] cnt, cnt_n;
  assign g1_ev = goal_p1 & ~g1_q;
  assign g2_ev = goal_p2 & ~g2_q;
  assign st_ev = start & ~st_q;
  assign pause_end = frame_tick && cnt == CW'(PAUSE_FRAMES - 1);
  assign blink_end = frame_tick && cnt == CW'(BLINK_FRAMES - 1);
  always_comb begin
    state_n  = state;
    p1_n     = point1;
    p2_n     = point2;
    cnt_n    = cnt;
    blink_n  = blink;
    winner_n = winner;
    case (state)
      IDLE: if (st_ev) begin
        p1_n    = '0;
        p2_n    = '0;
        cnt_n   = '0;
        state_n = PLAY;
      end
      // simultaneous goals cancel each other out
      PLAY: if (g1_ev ^ g2_ev) begin
        p1_n     = point1 + {3'd0, g1_ev && point1 < 4'(WIN_SCORE)};
        p2_n     = point2 + {3'd0, g2_ev && point2 < 4'(WIN_SCORE)};
        cnt_n    = '0;
        blink_n  = 1'b1;
        state_n  = (p1_n == 4'(WIN_SCORE) || p2_n == 4'(WIN_SCORE)) ? OVER : SCORED;
        winner_n = state_n == OVER ? g2_ev : winner;
      end
      SCORED: if (frame_tick) begin
        cnt_n   = pause_end ? '0 : cnt + 1'b1;
        state_n = pause_end ? PLAY : SCORED;
      end
      OVER: if (st_ev) begin
        p1_n    = '0;
        p2_n    = '0;
        cnt_n   = '0;
        blink_n = 1'b1;
        state_n = PLAY;
      end else if (frame_tick) begin
        cnt_n   = blink_end ? '0 : cnt + 1'b1;
        blink_n = blink ^ blink_end;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      point1 <= '0;
      point2 <= '0;
      cnt    <= '0;
      blink  <= 1'b1;
      winner <= 1'b0;
      g1_q   <= 1'b0;
      g2_q   <= 1'b0;
      st_q   <= 1'b0;
    end else begin
      state  <= state_n;
      point1 <= p1_n;
      point2 <= p2_n;
      cnt    <= cnt_n;
      blink  <= blink_n;
      winner <= winner_n;
      g1_q   <= goal_p1;
      g2_q   <= goal_p2;
      st_q   <= start;
    end
  end
  assign ball_run  = state == PLAY;
  assign game_over = state == OVER;
  assign digit_en1 = ~game_over | winner | blink;
  assign digit_en2 = ~game_over | ~winner | blink;
endmodule

// File: tb/tb_pong_score_ctrl.sv
// tb_pong_score_ctrl: randomized frame ticks and goals against a frame-counting match model
module tb_pong_score_ctrl;
  localparam int WIN = 9, PAUSE = 60, BLINK = 30;
  logic clk = 0, reset = 1, frame_tick = 0, start = 1, goal_p1 = 0, goal_p2 = 0;
  logic [3:0] point1, point2;
  logic digit_en1, digit_en2, ball_run, game_over, winner;
  logic [12:0] obs;
  int errors = 0, checks = 0;
  typedef enum {M_IDLE, M_PLAY, M_PAUSE, M_OVER} mode_t;
  mode_t m_mode = M_IDLE;
  int m_s1 = 0, m_s2 = 0, m_rem = 0, m_over_ticks = 0;
  bit m_win = 0, m_g1p = 0, m_g2p = 0, m_stp = 0;

  pong_score_ctrl dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .start(start),
    .goal_p1(goal_p1), .goal_p2(goal_p2), .point1(point1), .point2(point2),
    .digit_en1(digit_en1), .digit_en2(digit_en2), .ball_run(ball_run),
    .game_over(game_over), .winner(winner)
  );

  always #5 clk = ~clk;
  assign obs = {point1, point2, ball_run, game_over, digit_en1, digit_en2, game_over & winner};

  function automatic bit exp_en(input bit p2);
    if (m_mode != M_OVER || m_win != p2) return 1'b1;
    return ((m_over_ticks / BLINK) % 2) == 0;
  endfunction

  function automatic logic [12:0] exp_vec();
    return {4'(m_s1), 4'(m_s2), m_mode == M_PLAY, m_mode == M_OVER, exp_en(0), exp_en(1),
            m_mode == M_OVER && m_win};
  endfunction

  task automatic model_update();
    bit e1, e2, es;
    e1 = goal_p1 && !m_g1p;
    e2 = goal_p2 && !m_g2p;
    es = start && !m_stp;
    m_g1p = goal_p1;
    m_g2p = goal_p2;
    m_stp = start;
    if (reset) begin
      m_mode = M_IDLE; m_s1 = 0; m_s2 = 0; m_win = 0;
      m_g1p = 0; m_g2p = 0; m_stp = 0;
    end else case (m_mode)
      M_IDLE: if (es) begin m_s1 = 0; m_s2 = 0; m_mode = M_PLAY; end
      M_PLAY: if (e1 != e2) begin
        if (e1 && m_s1 < WIN) m_s1++;
        if (e2 && m_s2 < WIN) m_s2++;
        if (m_s1 == WIN || m_s2 == WIN) begin m_mode = M_OVER; m_win = e2; m_over_ticks = 0; end
        else begin m_mode = M_PAUSE; m_rem = PAUSE; end
      end
      M_PAUSE: if (frame_tick) begin
        m_rem--;
        if (m_rem == 0) m_mode = M_PLAY;
      end
      M_OVER: if (es) begin m_s1 = 0; m_s2 = 0; m_mode = M_PLAY; end
        else if (frame_tick) m_over_ticks++;
    endcase
  endtask

  task automatic step();
    frame_tick = $urandom_range(0, 3) == 0;
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic test_reset();
    reset = 1; start = 1;
    repeat (3) step();
    checks++;
    if (obs !== exp_vec() || obs !== 13'b0000_0000_0_0_1_1_0) begin
      errors++; $display("FAIL reset_values: got %b expected %b", obs, exp_vec());
    end
    reset = 0; start = 0;
    step();
    checks++;
    if (ball_run !== 1'b0) begin errors++; $display("FAIL idle_hold: ball_run got %b expected 0", ball_run); end
    start = 1;
    step();
    checks++;
    if (obs !== exp_vec() || ball_run !== 1'b1) begin
      errors++; $display("FAIL start_to_play: got %b expected %b", obs, exp_vec());
    end
  endtask

  task automatic test_goal_hold();
    int n = 0;
    bit pre;
    for (int i = 0; i < 3000; i++) begin
      goal_p1 = i < 100;
      goal_p2 = i == 120;
      pre = ball_run;
      step();
      if (!pre && frame_tick) n++;
      checks++;
      if (obs !== exp_vec()) begin errors++; $display("FAIL goal_hold cyc %0d: got %b expected %b", i, obs, exp_vec()); end
      if (i > 100 && ball_run) break;
    end
    goal_p1 = 0; goal_p2 = 0;
    checks++;
    if (n != PAUSE) begin errors++; $display("FAIL pause_len: got %0d ticks expected %0d", n, PAUSE); end
    checks++;
    if (point1 !== 4'd1 || point2 !== 4'd0 || ball_run !== 1'b1) begin
      errors++; $display("FAIL hold_once: got p1=%0d p2=%0d run=%b expected 1 0 1", point1, point2, ball_run);
    end
  endtask

  task automatic test_simultaneous();
    goal_p1 = 1; goal_p2 = 1;
    step();
    goal_p1 = 0; goal_p2 = 0;
    repeat (4) begin
      step();
      checks++;
      if (obs !== exp_vec() || point1 !== 4'd1 || point2 !== 4'd0 || ball_run !== 1'b1) begin
        errors++; $display("FAIL simultaneous: got %b expected %b", obs, exp_vec());
      end
    end
  endtask

  task automatic test_win();
    int t1 = 0;
    bit prev_en2;
    for (int g = 0; g < WIN; g++) begin
      bit done = 0;
      goal_p2 = 1;
      step();
      goal_p2 = 0;
      for (int i = 0; i < 2000 && !done; i++) begin
        step();
        checks++;
        if (obs !== exp_vec()) begin errors++; $display("FAIL win_seq g%0d: got %b expected %b", g, obs, exp_vec()); end
        done = ball_run || game_over;
      end
      checks++;
      if (!done) begin errors++; $display("FAIL win_timeout g%0d: got stuck expected resume", g); end
    end
    checks++;
    if (point2 !== 4'd9 || game_over !== 1'b1 || winner !== 1'b1) begin
      errors++; $display("FAIL win_state: got p2=%0d over=%b win=%b expected 9 1 1", point2, game_over, winner);
    end
    prev_en2 = digit_en2;
    for (int i = 0; i < 500; i++) begin
      goal_p2 = (i % 10) == 0;
      step();
      if (digit_en2 !== prev_en2) t1++;
      prev_en2 = digit_en2;
      checks++;
      if (obs !== exp_vec() || digit_en1 !== 1'b1) begin
        errors++; $display("FAIL blink cyc %0d: got %b expected %b", i, obs, exp_vec());
      end
    end
    goal_p2 = 0;
    checks++;
    if (t1 == 0) begin errors++; $display("FAIL blink_toggle: got %0d toggles expected >0", t1); end
  endtask

  task automatic test_restart();
    start = 0;
    step();
    start = 1;
    step();
    checks++;
    if (obs !== exp_vec() || obs !== 13'b0000_0000_1_0_1_1_0) begin
      errors++; $display("FAIL restart: got %b expected %b", obs, exp_vec());
    end
  endtask

  task automatic test_reset_mid_pause();
    int n = 0;
    for (int g = 0; g < 3; g++) begin
      goal_p1 = 1;
      step();
      goal_p1 = 0;
      for (int i = 0; i < 2000 && g < 2 && !ball_run; i++) step();
    end
    for (int i = 0; i < 2000 && n < 20; i++) begin
      step();
      if (frame_tick) n++;
    end
    checks++;
    if (point1 !== 4'd3 || ball_run !== 1'b0 || n != 20) begin
      errors++; $display("FAIL pre_reset: got p1=%0d run=%b ticks=%0d expected 3 0 20", point1, ball_run, n);
    end
    reset = 1; start = 0;
    step();
    reset = 0;
    checks++;
    if (obs !== exp_vec() || point1 !== 4'd0 || ball_run !== 1'b0 || game_over !== 1'b0) begin
      errors++; $display("FAIL mid_pause_reset: got %b expected %b", obs, exp_vec());
    end
    repeat (3) step();
    checks++;
    if (ball_run !== 1'b0) begin errors++; $display("FAIL idle_after_reset: ball_run got %b expected 0", ball_run); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 19) == 0) goal_p1 = ~goal_p1;
      if ($urandom_range(0, 19) == 0) goal_p2 = ~goal_p2;
      if ($urandom_range(0, 49) == 0) start = ~start;
      reset = $urandom_range(0, 499) == 0;
      step();
      checks++;
      if (obs !== exp_vec()) begin errors++; $display("FAIL random cyc %0d: got %b expected %b", i, obs, exp_vec()); end
    end
    reset = 0;
  endtask

  initial begin
    test_reset();
    test_goal_hold();
    test_simultaneous();
    test_win();
    test_restart();
    test_reset_mid_pause();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
